// File: rtl/gf256_log_inverter.sv
// GF(2^8) multiplicative inverse (AES polynomial 0x11B) via log/antilog tables with generator 0x03.
// Provides a combinational result and a registered, valid-qualified copy.
module gf256_log_inverter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       in_valid,
  output logic [7:0] byte_out,
  output logic [7:0] byte_out_q,
  output logic       out_valid
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] pow3(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) begin
      r = xtime(r) ^ r;
    end
    pow3 = r;
  endfunction

  // Discrete log base 0x03; the zero entry is never selected and reads as 0.
  function automatic logic [7:0] log3(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] res;
    r   = 8'h01;
    res = 8'h00;
    for (int i = 0; i < 255; i++) begin
      if (r == x) begin
        res = 8'(i);
      end
      r = xtime(r) ^ r;
    end
    log3 = res;
  endfunction

  logic [7:0] alog_s [256];
  logic [7:0] log_s  [256];

  for (genvar g = 0; g < 256; g++) begin : g_tables
    localparam logic [7:0] ALOG_V = pow3(g);
    localparam logic [7:0] LOG_V  = log3(8'(g));
    assign alog_s[g] = ALOG_V;
    assign log_s[g]  = LOG_V;
  end

  logic [7:0] log_x_s;
  logic [7:0] e_inv_s;
  logic [7:0] inv_s;

  // Exponent negation mod 255: LOG = 0 must map to 0, not 255.
  always_comb begin
    log_x_s = log_s[byte_in];
    if (log_x_s == 8'h00) begin
      e_inv_s = 8'h00;
    end else begin
      e_inv_s = 8'hFF - log_x_s;
    end
    if (byte_in == 8'h00) begin
      inv_s = 8'h00;
    end else begin
      inv_s = alog_s[e_inv_s];
    end
  end

  assign byte_out = inv_s;

  logic [7:0] inv_d;
  logic [7:0] inv_q;
  logic       valid_d;
  logic       valid_q;

  always_comb begin
    inv_d   = inv_q;
    valid_d = 1'b0;
    if (in_valid) begin
      inv_d   = inv_s;
      valid_d = 1'b1;
    end else begin
      inv_d   = inv_q;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      inv_q   <= inv_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out_q = inv_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_gf256_log_inverter.sv
// Directed self-checking bench for gf256_log_inverter against a brute-force GF(2^8) inverse model.
module tb_gf256_log_inverter;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       in_valid;
  logic [7:0] byte_out;
  logic [7:0] byte_out_q;
  logic       out_valid;

  int n_cmp;
  int n_bad;
  logic [7:0] ref_inv [256];
  logic [7:0] first_out;
  logic [7:0] rnd;

  gf256_log_inverter dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .in_valid  (in_valid),
    .byte_out  (byte_out),
    .byte_out_q(byte_out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    byte_in = 8'h00;

    // Brute-force reference inverse table.
    ref_inv[0] = 8'h00;
    for (int x = 1; x < 256; x++) begin
      ref_inv[x] = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) ref_inv[x] = 8'(y);
      end
    end

    step();
    step();
    check_eq("reset_q", byte_out_q, 8'h00);
    check_eq("reset_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed samples, including the LOG = 0 wrap case.
    byte_in = 8'h00; #1 check_eq("s00", byte_out, 8'h00);
    byte_in = 8'h01; #1 check_eq("s01_wrap", byte_out, 8'h01);
    byte_in = 8'h02; #1 check_eq("s02", byte_out, 8'h8D);
    byte_in = 8'h03; #1 check_eq("s03_log1", byte_out, 8'hF6);
    byte_in = 8'h53; #1 check_eq("s53", byte_out, 8'hCA);
    byte_in = 8'h80; #1 check_eq("s80", byte_out, 8'h83);
    byte_in = 8'hFF; #1 check_eq("sFF", byte_out, 8'h1C);

    // Exhaustive combinational sweep with algebraic self-checks.
    for (int x = 0; x < 256; x++) begin
      byte_in = 8'(x);
      #1;
      check_eq("sweep", byte_out, ref_inv[x]);
      if (x != 0) check_eq("mul_one", gf_mul(8'(x), byte_out), 8'h01);
      first_out = byte_out;
      byte_in = first_out;
      #1;
      check_eq("inv_inv", byte_out, 8'(x));
    end

    // Back-to-back pipeline.
    @(negedge clk);
    in_valid = 1'b1; byte_in = 8'h02;
    step(); check_eq("pipe0_q", byte_out_q, 8'h8D); check_eq("pipe0_v", {7'd0, out_valid}, 8'h01);
    @(negedge clk); byte_in = 8'h53;
    step(); check_eq("pipe1_q", byte_out_q, 8'hCA); check_eq("pipe1_v", {7'd0, out_valid}, 8'h01);
    @(negedge clk); byte_in = 8'hFF;
    step(); check_eq("pipe2_q", byte_out_q, 8'h1C); check_eq("pipe2_v", {7'd0, out_valid}, 8'h01);
    @(negedge clk); in_valid = 1'b0; byte_in = 8'h07;
    step(); check_eq("pipe_hold_q", byte_out_q, 8'h1C); check_eq("pipe_end_v", {7'd0, out_valid}, 8'h00);

    // Reset wins over in_valid; combinational path unaffected.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; byte_in = 8'h53;
    #1 check_eq("rst_comb_pre", byte_out, 8'hCA);
    step();
    check_eq("rst_q", byte_out_q, 8'h00);
    check_eq("rst_v", {7'd0, out_valid}, 8'h00);
    check_eq("rst_comb", byte_out, 8'hCA);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_eq("post_rst_v", {7'd0, out_valid}, 8'h00);
    check_eq("post_rst_q", byte_out_q, 8'h00);
    @(negedge clk);
    in_valid = 1'b1; byte_in = 8'h80;
    step();
    check_eq("first_after_rst_q", byte_out_q, 8'h83);
    check_eq("first_after_rst_v", {7'd0, out_valid}, 8'h01);

    // Idle: registered output holds while byte_in wanders.
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rnd = 8'($urandom_range(0, 255));
      byte_in = rnd;
      #1 check_eq("idle_comb", byte_out, ref_inv[rnd]);
      step();
      check_eq("idle_v", {7'd0, out_valid}, 8'h00);
      check_eq("idle_q", byte_out_q, 8'h83);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf256_log_inverter.md
Name: gf256_log_inverter

Overview:
- Computes the multiplicative inverse of a byte in GF(2^8) using the AES field polynomial x^8+x^4+x^3+x+1 (0x11B).
- Uses log/antilog lookup with generator 0x03.
- It is the inversion stage of the S-box datapath; the affine transform lives outside this block.
- Provides a zero-latency combinational result and a registered, valid-qualified copy for pipelined S-box use.

Parameters:
- None. The field polynomial (0x11B) and generator (0x03) are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- byte_in  input  8  field element to invert
- in_valid  input  1  qualifies byte_in for the registered path
- byte_out  output  8  combinational inverse of byte_in
- byte_out_q  output  8  registered inverse, one cycle after in_valid
- out_valid  output  1  qualifies byte_out_q

Behaviour:
- Field arithmetic:
  - Multiplication is modulo 0x11B.
  - inv(x) is the unique y with x*y = 1.
  - inv(0x00) is defined as 0x00 (AES convention).
- Log table LOG[x], x = 1..255:
  - e such that 0x03^e = x, with e in 0..254.
  - LOG[0x00] is unused and is don't-care internally.
- Antilog table ALOG[e], e = 0..254:
  - Equals 0x03^e.
  - ALOG[0] = 0x01, ALOG[1] = 0x03, ALOG[2] = 0x05.
- Inverse computation:
  - e_inv = (255 - LOG[x]) mod 255, computed in 8 bits.
  - LOG[x] = 0 maps to e_inv = 0, not 255; this wrap case must be handled explicitly.
  - byte_out = ALOG[e_inv].
- Zero detection:
  - When byte_in == 0x00, byte_out is forced to 0x00, overriding the table path.
- Tables:
  - May be constant case ROMs or generated at elaboration by iterating multiply-by-0x03 (x*3 = xtime(x) ^ x).
  - Contents must match the definitions above bit-exactly.
- byte_out is purely combinational:
  - Settles within the same cycle, with no dependence on clk or rst.
  - No X on any output for any fully defined input.
- Registered path, on each rising edge of clk:
  - If rst = 1: byte_out_q <= 0x00 and out_valid <= 0.
  - Else: out_valid <= in_valid; if in_valid = 1, byte_out_q <= inv(byte_in); otherwise byte_out_q holds.
- Latency and throughput:
  - Registered latency is 1 cycle.
  - Throughput is one byte per cycle, back-to-back with no bubbles.
- Reset:
  - Reset values: byte_out_q = 0x00, out_valid = 0.
  - byte_out is unaffected by rst.
  - Reset asserted mid-stream drops the in-flight result; the first valid output after reset release appears one cycle after the first in_valid sampled with rst = 0.
- rst and in_valid both high in the same cycle: rst wins; nothing is captured.

Test Plan:
- Exhaustive sweep, combinational path: byte_in = 0x00..0xFF, checking byte_out against a precomputed 256-entry inverse table after settle. Sample values: 0x00→0x00, 0x01→0x01, 0x02→0x8D, 0x03→0xF6, 0x53→0xCA, 0x80→0x83, 0xFF→0x1C.
- Self-check: for every x ≠ 0, reference GF multiply x * byte_out == 0x01; byte_out is never 0 for x ≠ 0; inv(inv(x)) == x for all x.
- Wrap boundary: byte_in = 0x01 (LOG = 0) → byte_out = 0x01, with no exponent-255 overflow; byte_in = 0x03 (LOG = 1) → 0xF6.
- Pipeline: after reset, drive in_valid = 1 with 0x02, 0x53, 0xFF on consecutive cycles, then in_valid = 0. Expect byte_out_q = 0x8D, 0xCA, 0x1C with out_valid = 1 on the following three cycles, then out_valid = 0 with byte_out_q holding 0x1C.
- Reset: assert rst for one cycle while in_valid = 1 and byte_in = 0x53. Next cycle byte_out_q = 0x00 and out_valid = 0, while combinational byte_out = 0xCA throughout.
- Idle: in_valid = 0 for 10 cycles with random byte_in. out_valid stays 0, byte_out_q stays unchanged, and byte_out tracks the inverse each cycle.
